matmul_flow_controller: RTL and testbench

Issues matrix-multiply instructions. Streams rows from the unified buffer into the systolic data setup/MMU, and generates the matching accumulator write address, enable and accumulate flag, aligned with MMU output latency. This is the producer side of the accumulator interface. Rows it writes are later read by the activation path and returned to the buffer.

---
 rtl/matmul_flow_controller.sv | 104 ++++++++++
 tb/tb_matmul_flow_controller.sv | 132 +++++++++++++
 2 files changed

// File: rtl/matmul_flow_controller.sv
// matmul_flow_controller: issues matmul row reads to the unified buffer and emits the
// matching accumulator writes once the rows have passed through the systolic array.
package matmul_pkg;
    localparam int BUFFER_ADDR_WIDTH = 8;
    localparam int ACCUMULATOR_ADDR_WIDTH = 8;
    localparam int LENGTH_WIDTH = 8;
    typedef struct packed {
        logic [1:0]                        opcode;
        logic [LENGTH_WIDTH-1:0]           length;
        logic [ACCUMULATOR_ADDR_WIDTH-1:0] acc_addr;
        logic [BUFFER_ADDR_WIDTH-1:0]      buffer_addr;
    } instr_type;
endpackage

module matmul_flow_controller
    import matmul_pkg::*;
#(
    parameter int MATRIX_WIDTH = 14
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  instr_type                         instr,
    input  logic                              instr_enable,
    output logic [BUFFER_ADDR_WIDTH-1:0]      buf_read_addr,
    output logic                              buf_read_en,
    output logic                              mmu_sds_enable,
    output logic                              mmu_signed,
    output logic [ACCUMULATOR_ADDR_WIDTH-1:0] acc_addr,
    output logic                              acc_enable,
    output logic                              accumulate,
    output logic                              busy,
    output logic                              resource_busy
);
    localparam int D = MATRIX_WIDTH + 3;
    localparam int BW = BUFFER_ADDR_WIDTH;
    localparam int AW = ACCUMULATOR_ADDR_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    logic [BW-1:0]           buf_base;
    logic [AW-1:0]           acc_base;
    logic [LENGTH_WIDTH-1:0] count, last;
    logic                    acc_flag, sign_flag, sds, sds_signed;
    logic [D-1:0]            pipe_valid, pipe_acc;
    logic [AW-1:0]           pipe_addr [D];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else if (enable) state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE ? (instr_enable ? RUN : IDLE)
                                   : (count == last ? IDLE : RUN);
    end

    always_comb begin
        busy           = state == RUN;
        buf_read_en    = busy;
        buf_read_addr  = busy ? buf_base + BW'(count) : '0;
        mmu_sds_enable = sds;
        mmu_signed     = sds_signed;
        acc_enable     = pipe_valid[D-1];
        acc_addr       = pipe_addr[D-1];
        accumulate     = pipe_acc[D-1];
        resource_busy  = busy | (|pipe_valid);
    end

    // Each delay stage carries its own addr/flag, so consecutive instructions can overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_base   <= '0;
            acc_base   <= '0;
            count      <= '0;
            last       <= '0;
            acc_flag   <= 1'b0;
            sign_flag  <= 1'b0;
            sds        <= 1'b0;
            sds_signed <= 1'b0;
            pipe_valid <= '0;
            pipe_acc   <= '0;
            for (int i = 0; i < D; i++) pipe_addr[i] <= '0;
        end else if (enable) begin
            if (state == IDLE && instr_enable) begin
                buf_base  <= instr.buffer_addr;
                acc_base  <= instr.acc_addr;
                acc_flag  <= instr.opcode[0];
                sign_flag <= instr.opcode[1];
                count     <= '0;
                last      <= instr.length == '0 ? '0 : instr.length - 1'b1;
            end else if (busy) begin
                count <= count + 1'b1;
            end
            sds          <= busy;
            sds_signed   <= busy & sign_flag;
            pipe_valid   <= {pipe_valid[D-2:0], busy};
            pipe_acc     <= {pipe_acc[D-2:0], busy & acc_flag};
            pipe_addr[0] <= busy ? acc_base + AW'(count) : '0;
            for (int i = 1; i < D; i++) pipe_addr[i] <= pipe_addr[i-1];
        end
    end
endmodule

// File: tb/tb_matmul_flow_controller.sv
// tb_matmul_flow_controller: directed checks of read issue, accumulator write timing,
// overlap, wrap, stall and mid-run reset with MATRIX_WIDTH=4 (D=7).
module tb_matmul_flow_controller;
    import matmul_pkg::*;

    localparam int D = 7;

    logic       clk = 1'b0;
    logic       rst, enable, instr_enable;
    instr_type  instr;
    logic [7:0] buf_read_addr, acc_addr;
    logic       buf_read_en, mmu_sds_enable, mmu_signed, acc_enable, accumulate;
    logic       busy, resource_busy;
    int         cmps = 0;
    int         errs = 0;

    matmul_flow_controller #(.MATRIX_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .instr(instr), .instr_enable(instr_enable),
        .buf_read_addr(buf_read_addr), .buf_read_en(buf_read_en),
        .mmu_sds_enable(mmu_sds_enable), .mmu_signed(mmu_signed),
        .acc_addr(acc_addr), .acc_enable(acc_enable), .accumulate(accumulate),
        .busy(busy), .resource_busy(resource_busy)
    );

    always #5 clk = ~clk;

    // Expected outputs at cycle T+n for one instruction issued at T.
    function automatic logic [22:0] model(int n, int len, int b, int a, logic af, logic sf);
        int   l   = len == 0 ? 1 : len;
        logic rd  = n >= 1 && n <= l;
        logic sds = n >= 2 && n <= l + 1;
        logic ae  = n >= 1 + D && n <= l + D;
        return {rd, rd ? 8'(b + n - 1) : 8'h00, sds, sds & sf,
                ae, ae ? 8'(a + n - 1 - D) : 8'h00, ae & af, rd, n >= 1 && n <= l + D};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, int n, logic [22:0] exp);
        logic [22:0] obs;
        obs = {buf_read_en, buf_read_addr, mmu_sds_enable, mmu_signed,
               acc_enable, acc_addr, accumulate, busy, resource_busy};
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s n=%0d observed=%06h expected=%06h", tag, n, obs, exp);
        end
    endtask

    task automatic issue(int len, int b, int a, logic [1:0] op);
        instr.opcode      = op;
        instr.length      = 8'(len);
        instr.buffer_addr = 8'(b);
        instr.acc_addr    = 8'(a);
        instr_enable      = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        instr_enable = 1'b0;
        instr = '0;
        tick();
        tick();
        check("reset", 0, 23'h0);
        rst = 1'b0;
        tick();
        check("idle", 0, 23'h0);

        // Basic length-3 overwrite
        issue(3, 'h10, 'h20, 2'b00);
        check("basic", 0, model(0, 3, 'h10, 'h20, 0, 0));
        for (int n = 1; n <= 12; n++) begin
            tick();
            instr_enable = 1'b0;
            check("basic", n, model(n, 3, 'h10, 'h20, 0, 0));
        end

        // Length 0 treated as one row, signed + accumulate
        issue(0, 'h30, 'h50, 2'b11);
        for (int n = 1; n <= 10; n++) begin
            tick();
            instr_enable = 1'b0;
            check("len0", n, model(n, 0, 'h30, 'h50, 1, 1));
        end

        // Pulse while busy is ignored; second instruction accepted at T+4
        issue(3, 'h10, 'h20, 2'b00);
        for (int n = 1; n <= 15; n++) begin
            tick();
            instr_enable = 1'b0;
            check("b2b", n, model(n, 3, 'h10, 'h20, 0, 0) | model(n - 4, 2, 'h60, 'h40, 1, 0));
            if (n == 2) issue(3, 'h80, 'h90, 2'b11);
            if (n == 4) issue(2, 'h60, 'h40, 2'b01);
        end

        // Buffer address wrap
        issue(3, 'hFE, 'hFF, 2'b00);
        for (int n = 1; n <= 11; n++) begin
            tick();
            instr_enable = 1'b0;
            check("wrap", n, model(n, 3, 'hFE, 'hFF, 0, 0));
        end

        // enable low for 5 cycles starting at T+2 stretches everything by 5
        issue(3, 'h10, 'h20, 2'b10);
        for (int n = 1; n <= 16; n++) begin
            tick();
            instr_enable = 1'b0;
            enable = 1'b1;
            check("stall", n, model(n <= 2 ? n : n <= 7 ? 2 : n - 5, 3, 'h10, 'h20, 0, 1));
            if (n >= 2 && n <= 6) enable = 1'b0;
        end
        enable = 1'b1;

        // Reset at T+2 aborts the instruction
        issue(3, 'h10, 'h20, 2'b01);
        for (int n = 1; n <= 14; n++) begin
            tick();
            instr_enable = 1'b0;
            rst = 1'b0;
            check("midrst", n, n <= 2 ? model(n, 3, 'h10, 'h20, 1, 0) : 23'h0);
            if (n == 2) rst = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
